// File: rtl/snow3g_pkg.sv
// Shared SNOW 3G LFSR definitions: state encoding, constants and the
// GF(2^8) helpers used to build the MULalpha / DIValpha networks.
package snow3g_pkg;

  localparam logic [7:0]  POLY_DEF = 8'hA9;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INIT,
    ST_DISCARD,
    ST_RUN
  } state_t;

  typedef logic [7:0][31:0] basis_t;

  function automatic logic [7:0] mulx(input logic [7:0] v, input logic [7:0] c);
    return {v[6:0], 1'b0} ^ (v[7] ? c : 8'h00);
  endfunction

  function automatic logic [7:0] mulxpow(input logic [7:0] v, input int unsigned i,
                                         input logic [7:0] c);
    logic [7:0] r;
    r = v;
    for (int k = 0; k < 256; k++) begin
      if (k < i) r = mulx(r, c);
    end
    return r;
  endfunction

  function automatic logic [31:0] mul_alpha(input logic [7:0] c, input logic [7:0] poly);
    return {mulxpow(c, 23, poly), mulxpow(c, 245, poly),
            mulxpow(c, 48, poly), mulxpow(c, 239, poly)};
  endfunction

  function automatic logic [31:0] div_alpha(input logic [7:0] c, input logic [7:0] poly);
    return {mulxpow(c, 16, poly), mulxpow(c, 39, poly),
            mulxpow(c, 6, poly), mulxpow(c, 64, poly)};
  endfunction

  // Both maps are GF(2)-linear in c, so the images of the 8 unit bytes
  // fully describe each 256-entry table.
  function automatic basis_t mul_alpha_basis(input logic [7:0] poly);
    basis_t b;
    for (int k = 0; k < 8; k++) b[k] = mul_alpha(8'h01 << k, poly);
    return b;
  endfunction

  function automatic basis_t div_alpha_basis(input logic [7:0] poly);
    basis_t b;
    for (int k = 0; k < 8; k++) b[k] = div_alpha(8'h01 << k, poly);
    return b;
  endfunction

endpackage

// File: rtl/snow3g_alpha_mul.sv
// Combinational MULalpha / DIValpha of one byte; zero latency, no handshake.
// XOR network over elaboration-time basis constants.
module snow3g_alpha_mul
  import snow3g_pkg::*;
#(
  parameter logic [7:0] POLY = POLY_DEF
) (
  input  logic [7:0]  i_c,
  output logic [31:0] o_mul,
  output logic [31:0] o_div
);

  localparam basis_t MUL_BASIS = mul_alpha_basis(POLY);
  localparam basis_t DIV_BASIS = div_alpha_basis(POLY);

  always_comb begin
    o_mul = '0;
    o_div = '0;
    for (int k = 0; k < 8; k++) begin
      if (i_c[k]) begin
        o_mul = o_mul ^ MUL_BASIS[k];
        o_div = o_div ^ DIV_BASIS[k];
      end
    end
  end

endmodule

// File: rtl/snow3g_lfsr_engine.sv
// SNOW 3G 16x32 LFSR with load / init / discard sequencing; one step per cycle.
// Steps follow step_o; start_i aborts and reloads, adv_i only acts in RUN.
module snow3g_lfsr_engine
  import snow3g_pkg::*;
#(
  parameter logic [7:0]  POLY        = POLY_DEF,
  parameter int unsigned INIT_ROUNDS = 32,
  parameter bit          DISCARD_EN  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] iv_i,
  input  logic [31:0]  f_i,
  input  logic         adv_i,
  output logic [31:0]  s0_o,
  output logic [31:0]  s5_o,
  output logic [31:0]  s15_o,
  output logic         step_o,
  output logic         init_mode_o,
  output logic         ready_o,
  output logic         busy_o
);

  logic [15:0][31:0] r_s;
  state_t            r_state;
  logic [7:0]        r_cnt;
  logic              r_init_mode;
  logic              r_fixed_step;
  logic              r_busy;
  logic              r_ready;

  logic [31:0] w_mul, w_div, w_fb;
  logic [31:0] w_k0, w_k1, w_k2, w_k3, w_iv0, w_iv1, w_iv2, w_iv3;
  logic        w_step;

  assign {w_k0, w_k1, w_k2, w_k3}     = key_i;
  assign {w_iv0, w_iv1, w_iv2, w_iv3} = iv_i;

  snow3g_alpha_mul #(.POLY(POLY)) u_mul_s0 (
    .i_c   (r_s[0][31:24]),
    .o_mul (w_mul),
    .o_div ()
  );

  snow3g_alpha_mul #(.POLY(POLY)) u_div_s11 (
    .i_c   (r_s[11][7:0]),
    .o_mul (),
    .o_div (w_div)
  );

  assign w_fb = {r_s[0][23:0], 8'h00} ^ w_mul ^ r_s[2] ^ {8'h00, r_s[11][31:8]} ^ w_div
              ^ (r_init_mode ? f_i : 32'h0);

  // A reload on this edge replaces any step, so the FSM must not clock either.
  assign w_step = !start_i && (r_fixed_step || (r_ready && adv_i));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s          <= '0;
      r_state      <= ST_IDLE;
      r_cnt        <= 8'd0;
      r_init_mode  <= 1'b0;
      r_fixed_step <= 1'b0;
      r_busy       <= 1'b0;
      r_ready      <= 1'b0;
    end else if (start_i) begin
      r_s[15]      <= w_k3 ^ w_iv0;
      r_s[14]      <= w_k2;
      r_s[13]      <= w_k1;
      r_s[12]      <= w_k0 ^ w_iv1;
      r_s[11]      <= w_k3 ^ ALL_ONES;
      r_s[10]      <= w_k2 ^ ALL_ONES ^ w_iv2;
      r_s[9]       <= w_k1 ^ ALL_ONES ^ w_iv3;
      r_s[8]       <= w_k0 ^ ALL_ONES;
      r_s[7]       <= w_k3;
      r_s[6]       <= w_k2;
      r_s[5]       <= w_k1;
      r_s[4]       <= w_k0;
      r_s[3]       <= w_k3 ^ ALL_ONES;
      r_s[2]       <= w_k2 ^ ALL_ONES;
      r_s[1]       <= w_k1 ^ ALL_ONES;
      r_s[0]       <= w_k0 ^ ALL_ONES;
      r_state      <= ST_LOAD;
      r_cnt        <= 8'd0;
      r_init_mode  <= 1'b0;
      r_fixed_step <= 1'b0;
      r_busy       <= 1'b1;
      r_ready      <= 1'b0;
    end else begin
      if (w_step) r_s <= {w_fb, r_s[15:1]};
      case (r_state)
        ST_LOAD: begin
          r_state      <= ST_INIT;
          r_init_mode  <= 1'b1;
          r_fixed_step <= 1'b1;
        end
        ST_INIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == 8'(INIT_ROUNDS - 1)) begin
            r_init_mode <= 1'b0;
            if (DISCARD_EN) begin
              r_state <= ST_DISCARD;
            end else begin
              r_state      <= ST_RUN;
              r_fixed_step <= 1'b0;
              r_busy       <= 1'b0;
              r_ready      <= 1'b1;
            end
          end
        end
        ST_DISCARD: begin
          r_state      <= ST_RUN;
          r_fixed_step <= 1'b0;
          r_busy       <= 1'b0;
          r_ready      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign s0_o        = r_s[0];
  assign s5_o        = r_s[5];
  assign s15_o       = r_s[15];
  assign step_o      = w_step;
  assign init_mode_o = r_init_mode;
  assign ready_o     = r_ready;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_snow3g_lfsr_engine.sv
// Directed bench for snow3g_lfsr_engine with a reference SNOW 3G FSM driving f_i;
// also sweeps snow3g_alpha_mul against a MULxPOW golden model.
module tb_snow3g_lfsr_engine;

  logic         clk = 1'b0;
  logic         rst_n, start_i, adv_i;
  logic [127:0] key_i, iv_i;
  logic [31:0]  f_i, s0_o, s5_o, s15_o;
  logic         step_o, init_mode_o, ready_o, busy_o;
  logic [7:0]   a_in;
  logic [31:0]  a_mul, a_div;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  sr_tab [256];
  logic [7:0]  sq_tab [256];
  logic [31:0] r1, r2, r3;

  localparam logic [127:0] TS1_KEY = 128'h2BD6459F82C5B300952C49104881FF48;
  localparam logic [127:0] TS1_IV  = 128'hEA024714AD5C4D84DF1F9B251C0BF45F;

  always #5 clk = ~clk;

  snow3g_lfsr_engine dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .key_i(key_i), .iv_i(iv_i),
    .f_i(f_i), .adv_i(adv_i), .s0_o(s0_o), .s5_o(s5_o), .s15_o(s15_o),
    .step_o(step_o), .init_mode_o(init_mode_o), .ready_o(ready_o), .busy_o(busy_o)
  );

  snow3g_alpha_mul u_alpha (.i_c(a_in), .o_mul(a_mul), .o_div(a_div));

  function automatic logic [7:0] xt(input logic [7:0] v, input logic [7:0] c);
    return v[7] ? ({v[6:0], 1'b0} ^ c) : {v[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] p);
    logic [7:0] acc = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ a;
      a = xt(a, p);
    end
    return acc;
  endfunction

  function automatic logic [7:0] gxp(input logic [7:0] v, input int n);
    for (int k = 0; k < n; k++) v = xt(v, 8'hA9);
    return v;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S1 uses the AES S-box with 0x1B, S2 uses SQ with 0x69.
  function automatic logic [31:0] smix(input logic [31:0] w, input bit use_q);
    logic [7:0] s [4];
    logic [7:0] p;
    p = use_q ? 8'h69 : 8'h1B;
    for (int k = 0; k < 4; k++) s[k] = use_q ? sq_tab[w[31-8*k -: 8]] : sr_tab[w[31-8*k -: 8]];
    return {xt(s[0],p) ^ s[1] ^ s[2] ^ xt(s[3],p) ^ s[3],
            xt(s[0],p) ^ s[0] ^ xt(s[1],p) ^ s[2] ^ s[3],
            s[0] ^ xt(s[1],p) ^ s[1] ^ xt(s[2],p) ^ s[3],
            s[0] ^ s[1] ^ xt(s[2],p) ^ s[2] ^ xt(s[3],p)};
  endfunction

  assign f_i = (s15_o + r1) ^ r2;

  always @(posedge clk) begin
    if (start_i) begin
      r1 <= 32'h0; r2 <= 32'h0; r3 <= 32'h0;
    end else if (step_o) begin
      r1 <= r2 + (r3 ^ s5_o);
      r2 <= smix(r1, 1'b0);
      r3 <= smix(r2, 1'b1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [127:0] k, input logic [127:0] v);
    key_i = k; iv_i = v; start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0]  b, acc;
    logic [31:0] z, prev_s0;
    logic [3:0]  pat;
    int cyc, n_init, n_disc, rdy_cyc, n_steps;

    rst_n = 1'b0; start_i = 1'b0; adv_i = 1'b0; key_i = '0; iv_i = '0; a_in = 8'h00;
    r1 = 32'h0; r2 = 32'h0; r3 = 32'h0;

    for (int x = 0; x < 256; x++) begin
      b = 8'h01;
      for (int k = 0; k < 254; k++) b = gmul(b, 8'(x), 8'h1B);
      sr_tab[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
      b = 8'h01; acc = 8'h25;
      for (int k = 1; k <= 49; k++) begin
        b = gmul(b, 8'(x), 8'h69);
        if (k inside {1, 9, 13, 15, 33, 41, 45, 47, 49}) acc = acc ^ b;
      end
      sq_tab[x] = acc;
    end

    for (int x = 0; x < 256; x++) begin
      a_in = 8'(x);
      #1;
      chk("alpha_mul", a_mul, {gxp(a_in,23), gxp(a_in,245), gxp(a_in,48), gxp(a_in,239)});
      chk("alpha_div", a_div, {gxp(a_in,16), gxp(a_in,39), gxp(a_in,6), gxp(a_in,64)});
    end
    a_in = 8'h00;
    #1;
    chk("alpha_zero_mul", a_mul, 32'h0);
    chk("alpha_zero_div", a_div, 32'h0);

    tick();
    chk("rst_s0", s0_o, 32'h0);
    chk("rst_s5", s5_o, 32'h0);
    chk("rst_s15", s15_o, 32'h0);
    chk("rst_flags", {28'h0, step_o, init_mode_o, ready_o, busy_o}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Zero key/IV: load pattern and cycle-exact sequencing.
    do_start('0, '0);
    chk1("load_busy", busy_o, 1'b1);
    chk1("load_nostep", step_o, 1'b0);
    tick();
    chk("zk_s0", s0_o, 32'hFFFF_FFFF);
    chk("zk_s5", s5_o, 32'h0);
    chk("zk_s15", s15_o, 32'h0);
    n_init = 0; n_disc = 0; rdy_cyc = -1;
    for (cyc = 2; cyc <= 40; cyc++) begin
      if (step_o && init_mode_o) n_init++;
      if (step_o && !init_mode_o) n_disc++;
      if (ready_o && rdy_cyc < 0) rdy_cyc = cyc;
      tick();
    end
    chk("init_steps", 32'(n_init), 32'd32);
    chk("discard_steps", 32'(n_disc), 32'd1);
    chk("ready_cycle", 32'(rdy_cyc), 32'd35);

    // Test set 1 keystream.
    do_start(TS1_KEY, TS1_IV);
    cyc = 0;
    while (!ready_o && cyc < 100) begin
      tick();
      cyc++;
    end
    chk1("ts1_ready", ready_o, 1'b1);
    z = f_i ^ s0_o;
    chk("ts1_z1", z, 32'hABEE9704);
    adv_i = 1'b1;
    #1;
    chk1("ts1_adv_step", step_o, 1'b1);
    tick();
    adv_i = 1'b0;
    #1;
    z = f_i ^ s0_o;
    chk("ts1_z2", z, 32'h7AC31373);

    // adv_i pattern 1,0,0,1 (applied LSB first).
    pat = 4'b1001;
    n_steps = 0;
    for (int k = 0; k < 4; k++) begin
      prev_s0 = s0_o;
      adv_i = pat[k];
      #1;
      if (step_o) n_steps++;
      tick();
      if (!pat[k]) chk("hold_s0", s0_o, prev_s0);
    end
    adv_i = 1'b0;
    chk("adv_steps", 32'(n_steps), 32'd2);

    // start_i together with adv_i: reload wins, no step.
    key_i = TS1_KEY; iv_i = TS1_IV; start_i = 1'b1; adv_i = 1'b1;
    #1;
    chk1("start_adv_nostep", step_o, 1'b0);
    tick();
    start_i = 1'b0; adv_i = 1'b0;
    chk1("reload_ready", ready_o, 1'b0);
    chk1("reload_busy", busy_o, 1'b1);
    tick();
    chk("reload_s0", s0_o, 32'hD429BA60);
    chk("reload_s5", s5_o, 32'h82C5B300);
    chk("reload_s15", s15_o, 32'hA283B85C);

    // Reset at cycle 10 after start.
    for (int k = 0; k < 8; k++) tick();
    chk1("mid_init_busy", busy_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mrst_s0", s0_o, 32'h0);
    chk("mrst_s5", s5_o, 32'h0);
    chk("mrst_s15", s15_o, 32'h0);
    chk("mrst_flags", {28'h0, step_o, init_mode_o, ready_o, busy_o}, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_idle", {28'h0, step_o, init_mode_o, ready_o, busy_o}, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snow3g_lfsr_engine.md
Name: snow3g_lfsr_engine

Overview:
- Sequential 16-stage x 32-bit SNOW 3G LFSR with built-in MULalpha and DIValpha feedback multipliers.
- Sequences key/IV load, the initialisation rounds (feedback XORed with the external FSM output F), one discard round, then on-demand keystream-mode clocking.
- Sits between the key/IV front end and the SNOW 3G FSM (S1/S2 + R1..R3). Exposes the taps the FSM needs and a step strobe, so the FSM updates on the same edge.

Parameters:
- POLY, 8'hA9, GF(2^8) reduction constant used by MULx inside MULalpha/DIValpha.
- INIT_ROUNDS, 32, number of initialisation-mode LFSR steps after load (1..255).
- DISCARD_EN, 1, when 1 one keystream-mode step without output follows init (per SNOW 3G); when 0 the engine goes straight to RUN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  single-cycle pulse; load key_i/iv_i and begin init
- key_i  in  128  K: key_i[127:96]=k0 ... key_i[31:0]=k3
- iv_i  in  128  IV: iv_i[127:96]=IV0 ... iv_i[31:0]=IV3
- f_i  in  32  FSM output F for the current cycle; used only in init mode
- adv_i  in  1  request one keystream-mode step (RUN only)
- s0_o  out  32  stage s0 (keystream z = F ^ s0 computed outside)
- s5_o  out  32  stage s5 (FSM input)
- s15_o  out  32  stage s15 (FSM input)
- step_o  out  1  LFSR clocks on this edge; FSM must clock too
- init_mode_o  out  1  high while the current step is an init-mode step
- ready_o  out  1  high in RUN; keystream words valid
- busy_o  out  1  high in LOAD/INIT/DISCARD

Behaviour:
- Reset (rst_n low, asynchronous): all 16 stages = 0, state IDLE, round counter = 0. s0_o/s5_o/s15_o = 0; step_o, init_mode_o, ready_o, busy_o = 0.
- States: IDLE, LOAD, INIT, DISCARD, RUN.
- IDLE: start_i -> LOAD.
- LOAD: one cycle. Stages are written with the SNOW 3G load pattern (1s = 32'hFFFFFFFF):
  - s15=k3^IV0, s14=k2, s13=k1, s12=k0^IV1
  - s11=k3^1s, s10=k2^1s^IV2, s9=k1^1s^IV3, s8=k0^1s
  - s7=k3, s6=k2, s5=k1, s4=k0
  - s3=k3^1s, s2=k2^1s, s1=k1^1s, s0=k0^1s
  - Counter is cleared; state goes to INIT.
- Feedback word: v = (s0<<8) ^ MULalpha(s0[31:24]) ^ s2 ^ (s11>>8) ^ DIValpha(s11[7:0]).
  - In init mode, v ^= f_i.
  - Shift: s_i <= s_(i+1) for i=0..14; s15 <= v.
- MULalpha(c) = {MULxPOW(c,23), MULxPOW(c,245), MULxPOW(c,48), MULxPOW(c,239)}.
- DIValpha(c) = {MULxPOW(c,16), MULxPOW(c,39), MULxPOW(c,6), MULxPOW(c,64)}.
  - Each byte is computed with POLY.
  - Implement as 256-entry constant tables generated at elaboration or as unrolled XOR networks. No recursion at runtime.
  - Purely combinational, same cycle.
- INIT: step every cycle; step_o=1, init_mode_o=1, counter increments. After INIT_ROUNDS steps -> DISCARD (DISCARD_EN=1) or RUN.
- DISCARD: exactly one step with step_o=1, init_mode_o=0, f_i ignored; then RUN.
- RUN: ready_o=1. Each cycle with adv_i=1 gives one keystream-mode step and step_o=1. With adv_i=0 the stages hold and step_o=0. Outputs s0/s5/s15 always reflect the current registers (combinational from regs, zero latency).
- Latency: start_i at cycle 0 -> LOAD at 1 -> INIT steps at cycles 2..INIT_ROUNDS+1 -> DISCARD at INIT_ROUNDS+2 -> ready_o at INIT_ROUNDS+3 (35 for defaults).
- Simultaneous events:
  - start_i is accepted in any state and wins over adv_i. It aborts the current sequence and reloads.
  - adv_i outside RUN is ignored.
- Counter width is 8 bits; no wrap occurs because INIT_ROUNDS ≤ 255.
- Reset mid-operation returns to the reset values immediately; no partial state survives.

Decomposition:
- Package snow3g_pkg: POLY default, state encoding, ALL_ONES constant, MULx/MULxPOW constant functions, MULalpha/DIValpha table generators.
- One sub-module: snow3g_alpha_mul. It is combinational, takes an 8-bit input and produces 32-bit MULalpha and DIValpha outputs. It is instantiated twice (s0 byte, s11 byte) and is testable stand-alone.

Test Plan:
- Reset mid-INIT (rst_n low at cycle 10 after start) -> all outputs 0, state IDLE within the same cycle; no step_o until the next start_i.
- key_i=0, iv_i=0, start_i -> after LOAD: s0_o=FFFFFFFF, s5_o=0, s15_o=0. Then exactly 32 step_o with init_mode_o=1, 1 with init_mode_o=0, and ready_o rises at cycle 35.
- snow3g_alpha_mul exhaustive over 0..255 -> matches golden MULxPOW model. Spot checks: input 0 -> 0 for both tables; MULalpha(8'h01)=MULxPOW(1,23..) word per golden.
- SNOW 3G test set 1: key 2BD6459F82C5B300952C49104881FF48, IV EA024714AD5C4D84DF1F9B251C0BF45F, with a bench FSM model driving f_i -> z words ABEE9704, 7AC31373.
- In RUN, toggle adv_i 1,0,0,1 -> exactly 2 step_o pulses and s0_o unchanged during the adv_i=0 cycles. start_i together with adv_i -> reload, no keystream step.
